// File: rtl/branch_target_buffer.sv
// Direct-mapped branch target buffer with a 1-bit taken flag per entry.
// Lookup is combinational; training and invalidation are registered.
module branch_target_buffer #(
  parameter int unsigned ENTRIES = 16,
  parameter int unsigned TAG_W   = 6
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] lk_pc,
  output logic        lk_hit,
  output logic        lk_taken,
  output logic [31:0] lk_next_pc,
  input  logic        upd_en,
  input  logic [31:0] upd_pc,
  input  logic        upd_taken,
  input  logic [31:0] upd_target,
  input  logic        flush_req,
  output logic        busy
);

  localparam int unsigned IDX_W = $clog2(ENTRIES);

  typedef enum logic {StIdle, StFlush} state_e;

  state_e             state_q, state_d;
  logic [IDX_W-1:0]   cnt_q, cnt_d;

  logic               valid_q  [ENTRIES];
  logic [TAG_W-1:0]   tag_q    [ENTRIES];
  logic [31:0]        target_q [ENTRIES];
  logic               taken_q  [ENTRIES];

  logic [IDX_W-1:0]   lk_idx, upd_idx;
  logic [TAG_W-1:0]   lk_tag, upd_tag;
  logic               upd_hit;
  logic               wr_alloc, wr_not_taken, clr_valid;

  // Low two bits and bits above the tag take no part in indexing or tagging.
  logic               unused_upd_bits;
  assign unused_upd_bits = ^{upd_pc[31:IDX_W+TAG_W+2], upd_pc[1:0]};

  assign lk_idx  = lk_pc[IDX_W+1:2];
  assign lk_tag  = lk_pc[IDX_W+TAG_W+1:IDX_W+2];
  assign upd_idx = upd_pc[IDX_W+1:2];
  assign upd_tag = upd_pc[IDX_W+TAG_W+1:IDX_W+2];

  assign busy    = (state_q == StFlush);
  assign upd_hit = valid_q[upd_idx] && (tag_q[upd_idx] == upd_tag);

  // Lookup: lookups always miss while the invalidate sequence runs.
  always_comb begin
    lk_hit     = valid_q[lk_idx] && (tag_q[lk_idx] == lk_tag) && !busy;
    lk_taken   = lk_hit && taken_q[lk_idx];
    lk_next_pc = lk_taken ? target_q[lk_idx] : lk_pc + 32'd4;
  end

  // Next-state and table write decode; flush request beats a same-cycle update.
  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    wr_alloc     = 1'b0;
    wr_not_taken = 1'b0;
    clr_valid    = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (flush_req) begin
          state_d = StFlush;
          cnt_d   = '0;
        end else if (upd_en) begin
          if (upd_taken) begin
            wr_alloc = 1'b1;
          end else if (upd_hit) begin
            wr_not_taken = 1'b1;
          end
        end
      end
      StFlush: begin
        clr_valid = 1'b1;
        cnt_d     = cnt_q + 1'b1;
        if (cnt_q == IDX_W'(ENTRIES - 1)) begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // Sequencer state register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= StIdle;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Table storage: allocate on taken, clear T on not-taken hit, drop V while flushing.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int unsigned i = 0; i < ENTRIES; i++) begin
        valid_q[i]  <= 1'b0;
        tag_q[i]    <= '0;
        target_q[i] <= '0;
        taken_q[i]  <= 1'b0;
      end
    end else begin
      if (wr_alloc) begin
        valid_q[upd_idx]  <= 1'b1;
        tag_q[upd_idx]    <= upd_tag;
        target_q[upd_idx] <= upd_target;
        taken_q[upd_idx]  <= 1'b1;
      end
      if (wr_not_taken) begin
        taken_q[upd_idx] <= 1'b0;
      end
      if (clr_valid) begin
        valid_q[cnt_q] <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_branch_target_buffer.sv
// Self-checking bench for branch_target_buffer: directed scenarios plus
// randomized traffic against an entry-level reference model.
module tb_branch_target_buffer;

  localparam int unsigned ENTRIES = 16;
  localparam int unsigned TAG_W   = 6;
  localparam int unsigned IDX_W   = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] lk_pc;
  logic        lk_hit, lk_taken;
  logic [31:0] lk_next_pc;
  logic        upd_en;
  logic [31:0] upd_pc;
  logic        upd_taken;
  logic [31:0] upd_target;
  logic        flush_req;
  logic        busy;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  branch_target_buffer #(.ENTRIES(ENTRIES), .TAG_W(TAG_W)) dut (
    .clk        (clk),
    .rst        (rst),
    .lk_pc      (lk_pc),
    .lk_hit     (lk_hit),
    .lk_taken   (lk_taken),
    .lk_next_pc (lk_next_pc),
    .upd_en     (upd_en),
    .upd_pc     (upd_pc),
    .upd_taken  (upd_taken),
    .upd_target (upd_target),
    .flush_req  (flush_req),
    .busy       (busy)
  );

  // Reference model: flush is modelled as an instant wipe plus a busy window.
  logic        m_v   [ENTRIES];
  int unsigned m_tag [ENTRIES];
  logic [31:0] m_ta  [ENTRIES];
  logic        m_t   [ENTRIES];
  int          m_busy_left;

  function automatic int unsigned idx_of(logic [31:0] pc);
    return (pc >> 2) % ENTRIES;
  endfunction

  function automatic int unsigned tag_of(logic [31:0] pc);
    return (pc >> (2 + IDX_W)) % (1 << TAG_W);
  endfunction

  function automatic logic exp_hit(logic [31:0] pc);
    return (m_busy_left == 0) && m_v[idx_of(pc)] && (m_tag[idx_of(pc)] == tag_of(pc));
  endfunction

  function automatic logic exp_taken(logic [31:0] pc);
    return exp_hit(pc) && m_t[idx_of(pc)];
  endfunction

  function automatic logic [31:0] exp_next(logic [31:0] pc);
    return exp_taken(pc) ? m_ta[idx_of(pc)] : pc + 32'd4;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < ENTRIES; i++) begin
      m_v[i] = 1'b0; m_tag[i] = 0; m_ta[i] = '0; m_t[i] = 1'b0;
    end
    m_busy_left = 0;
  endtask

  task automatic model_edge();
    int unsigned i;
    if (m_busy_left > 0) begin
      m_busy_left--;
    end else if (flush_req) begin
      for (int k = 0; k < ENTRIES; k++) m_v[k] = 1'b0;
      m_busy_left = ENTRIES;
    end else if (upd_en) begin
      i = idx_of(upd_pc);
      if (upd_taken) begin
        m_v[i] = 1'b1; m_tag[i] = tag_of(upd_pc); m_ta[i] = upd_target; m_t[i] = 1'b1;
      end else if (m_v[i] && m_tag[i] == tag_of(upd_pc)) begin
        m_t[i] = 1'b0;
      end
    end
  endtask

  // One clock: model follows the DUT at the rising edge, return at the falling edge.
  task automatic cycle();
    @(posedge clk);
    if (!rst) model_edge();
    @(negedge clk);
  endtask

  task automatic quiet();
    upd_en = 1'b0; upd_taken = 1'b0; flush_req = 1'b0;
  endtask

  task automatic train(input logic [31:0] pc, input logic tk, input logic [31:0] tgt);
    upd_en = 1'b1; upd_pc = pc; upd_taken = tk; upd_target = tgt;
    cycle();
    quiet();
  endtask

  task automatic test_reset();
    rst = 1'b1; model_reset(); quiet();
    upd_pc = '0; upd_target = '0; lk_pc = 32'h0000_0100;
    cycle(); cycle();
    rst = 1'b0;
    #1;
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL reset_busy: got %b want 0", busy); end
    checks++; if (lk_hit !== 1'b0) begin failures++; $display("FAIL reset_hit: got %b want 0", lk_hit); end
    checks++; if (lk_next_pc !== 32'h0000_0104) begin
      failures++; $display("FAIL reset_next: got %h want 00000104", lk_next_pc); end
  endtask

  task automatic test_train_taken();
    upd_en = 1'b1; upd_pc = 32'h40; upd_taken = 1'b1; upd_target = 32'h200; lk_pc = 32'h40;
    #1;
    checks++; if (lk_hit !== 1'b0) begin failures++; $display("FAIL no_bypass_hit: got %b want 0", lk_hit); end
    cycle(); quiet();
    #1;
    checks++; if (lk_hit !== 1'b1) begin failures++; $display("FAIL train_hit: got %b want 1", lk_hit); end
    checks++; if (lk_taken !== 1'b1) begin failures++; $display("FAIL train_taken: got %b want 1", lk_taken); end
    checks++; if (lk_next_pc !== 32'h200) begin
      failures++; $display("FAIL train_next: got %h want 00000200", lk_next_pc); end
  endtask

  task automatic test_not_taken();
    train(32'h40, 1'b0, 32'h0);
    lk_pc = 32'h40; #1;
    checks++; if (lk_hit !== 1'b1) begin failures++; $display("FAIL nt_hit: got %b want 1", lk_hit); end
    checks++; if (lk_taken !== 1'b0) begin failures++; $display("FAIL nt_taken: got %b want 0", lk_taken); end
    checks++; if (lk_next_pc !== 32'h44) begin
      failures++; $display("FAIL nt_next: got %h want 00000044", lk_next_pc); end
    train(32'h80, 1'b0, 32'h1234);
    lk_pc = 32'h80; #1;
    checks++; if (lk_hit !== 1'b0) begin failures++; $display("FAIL nt_noalloc_hit: got %b want 0", lk_hit); end
    checks++; if (lk_next_pc !== 32'h84) begin
      failures++; $display("FAIL nt_noalloc_next: got %h want 00000084", lk_next_pc); end
  endtask

  task automatic test_alias();
    train(32'h40, 1'b1, 32'h200);
    train(32'h440, 1'b1, 32'h300);
    lk_pc = 32'h40; #1;
    checks++; if (lk_hit !== 1'b0) begin failures++; $display("FAIL alias_old_hit: got %b want 0", lk_hit); end
    checks++; if (lk_next_pc !== 32'h44) begin
      failures++; $display("FAIL alias_old_next: got %h want 00000044", lk_next_pc); end
    lk_pc = 32'h440; #1;
    checks++; if (lk_next_pc !== 32'h300) begin
      failures++; $display("FAIL alias_new_next: got %h want 00000300", lk_next_pc); end
  endtask

  task automatic test_back_to_back();
    upd_en = 1'b1; upd_pc = 32'h10; upd_taken = 1'b1; upd_target = 32'h500;
    cycle();
    upd_target = 32'h600;
    cycle(); quiet();
    lk_pc = 32'h10; #1;
    checks++; if (lk_next_pc !== 32'h600) begin
      failures++; $display("FAIL b2b_next: got %h want 00000600", lk_next_pc); end
  endtask

  task automatic fill_all();
    for (int i = 0; i < ENTRIES; i++) train(32'h3040 + 32'(i * 4), 1'b1, 32'h8000 + 32'(i * 16));
  endtask

  task automatic test_flush();
    int n;
    fill_all();
    lk_pc = 32'h3040 + 32'd28; #1;
    checks++; if (lk_next_pc !== 32'h8070) begin
      failures++; $display("FAIL fill_next: got %h want 00008070", lk_next_pc); end
    // Flush together with an update to an unused index/tag.
    flush_req = 1'b1; upd_en = 1'b1; upd_pc = 32'h504; upd_taken = 1'b1; upd_target = 32'h9990;
    cycle(); quiet();
    n = 0;
    for (int k = 0; k < 40; k++) begin
      lk_pc = 32'h3040 + 32'((k % ENTRIES) * 4);
      flush_req = (k == 5);
      #1;
      if (busy !== 1'b1) break;
      n++;
      checks++; if (lk_hit !== 1'b0) begin failures++; $display("FAIL flush_window_hit: k=%0d got %b want 0", k, lk_hit); end
      cycle();
    end
    flush_req = 1'b0;
    checks++; if (n != ENTRIES) begin failures++; $display("FAIL flush_busy_len: got %0d want %0d", n, ENTRIES); end
    for (int i = 0; i < ENTRIES; i++) begin
      lk_pc = 32'h3040 + 32'(i * 4); #1;
      checks++; if (lk_hit !== 1'b0) begin failures++; $display("FAIL post_flush_hit: i=%0d got %b want 0", i, lk_hit); end
    end
    lk_pc = 32'h504; #1;
    checks++; if (lk_hit !== 1'b0) begin failures++; $display("FAIL flush_drop_upd: got %b want 0", lk_hit); end
  endtask

  task automatic test_reset_mid_flush_wrap();
    fill_all();
    flush_req = 1'b1; cycle(); quiet();
    for (int k = 0; k < 5; k++) cycle();
    rst = 1'b1; model_reset(); #1;
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL rst_flush_busy: got %b want 0", busy); end
    cycle();
    rst = 1'b0;
    for (int i = 0; i < ENTRIES; i++) begin
      lk_pc = 32'h3040 + 32'(i * 4); #1;
      checks++; if (lk_hit !== 1'b0) begin failures++; $display("FAIL rst_flush_hit: i=%0d got %b want 0", i, lk_hit); end
    end
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL rst_flush_busy2: got %b want 0", busy); end
    lk_pc = 32'hFFFF_FFFC; #1;
    checks++; if (lk_next_pc !== 32'h0) begin
      failures++; $display("FAIL wrap_next: got %h want 00000000", lk_next_pc); end
  endtask

  function automatic logic [31:0] rand_pc();
    logic [31:0] pc;
    pc = ($urandom_range(0, 3) << 6) | ($urandom_range(0, 15) << 2) | $urandom_range(0, 3);
    pc = pc | ($urandom_range(0, 1) << 20);
    if ($urandom_range(0, 31) == 0) pc = 32'hFFFF_FFFC;
    return pc;
  endfunction

  task automatic test_random();
    for (int c = 0; c < 500; c++) begin
      upd_en     = ($urandom_range(0, 2) != 0);
      upd_pc     = rand_pc();
      upd_taken  = $urandom_range(0, 1) == 1;
      upd_target = $urandom;
      flush_req  = ($urandom_range(0, 59) == 0);
      lk_pc      = rand_pc();
      #1;
      checks++; if (busy !== (m_busy_left != 0)) begin
        failures++; $display("FAIL rnd_busy: c=%0d got %b want %b", c, busy, m_busy_left != 0); end
      checks++; if (lk_hit !== exp_hit(lk_pc)) begin
        failures++; $display("FAIL rnd_hit: c=%0d pc=%h got %b want %b", c, lk_pc, lk_hit, exp_hit(lk_pc)); end
      checks++; if (lk_taken !== exp_taken(lk_pc)) begin
        failures++; $display("FAIL rnd_taken: c=%0d pc=%h got %b want %b", c, lk_pc, lk_taken, exp_taken(lk_pc)); end
      checks++; if (lk_next_pc !== exp_next(lk_pc)) begin
        failures++; $display("FAIL rnd_next: c=%0d pc=%h got %h want %h", c, lk_pc, lk_next_pc, exp_next(lk_pc)); end
      cycle();
    end
    quiet();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_train_taken();
    test_not_taken();
    test_alias();
    test_back_to_back();
    test_flush();
    test_reset_mid_flush_wrap();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/branch_target_buffer.md
# branch_target_buffer

Direct-mapped branch target buffer for the RISC-V-Lite fetch stage. It sits upstream of the PC-source mux and the hazard unit. Each cycle it takes the IF-stage PC and predicts the next fetch address, using one 1-bit taken flag per entry. It is trained by branch/jump resolution from the MEM stage. A multi-cycle invalidate sequencer clears the table on request, for example after a FENCE.I or an instruction-memory reload.

## Interface
- ENTRIES, 16, number of entries; power of two, 4..64; IDX_W = log2(ENTRIES)
- TAG_W, 6, tag width; fixed to match the CACHE_BRANCH.TAG field
- clk  in  1  single clock, rising edge
- rst  in  1  asynchronous, active-high reset
- lk_pc  in  32  IF-stage PC to look up
- lk_hit  out  1  valid entry with matching tag
- lk_taken  out  1  lk_hit & T
- lk_next_pc  out  32  predicted next fetch PC
- upd_en  in  1  resolution strobe from MEM, one cycle per resolved branch/jump
- upd_pc  in  32  PC of the resolved instruction
- upd_taken  in  1  resolved direction (jumps always 1)
- upd_target  in  32  resolved target address
- flush_req  in  1  request to invalidate the whole table
- busy  out  1  invalidate sequence in progress

## Operation
- **Entry layout:** each entry has the CACHE_BRANCH fields V, TAG[TAG_W-1:0], TA[31:0] and T.
- **Address slicing:**
  - index = pc[IDX_W+1:2]
  - tag = pc[IDX_W+TAG_W+1:IDX_W+2]
  - pc[1:0] is ignored.
- **Lookup (combinational from lk_pc and table state):**
  - lk_hit = V[idx] & (TAG[idx]==tag) & !busy
  - lk_next_pc = TA[idx] when lk_taken, else lk_pc + 4
  - The +4 wraps modulo 2^32.
- **Update (registered, only when state==IDLE):** the entry written is the one at upd_pc's index.
  - upd_en & upd_taken: write V=1, TAG=upd tag, TA=upd_target, T=1. Overwrites on conflict (tag mismatch replaces the old entry).
  - upd_en & !upd_taken & entry hit on upd_pc: T=0; TA and TAG are kept.
  - upd_en & !upd_taken & miss: no change (no allocation on not-taken).
- **FSM:**
  - States: IDLE and FLUSH; counter cnt is IDX_W bits.
  - IDLE -> FLUSH on flush_req, with cnt=0.
  - In FLUSH, each cycle V[cnt]=0 and cnt++.
  - FLUSH -> IDLE after the cycle that clears entry ENTRIES-1.
- **Priority:**
  - flush_req in IDLE wins over a same-cycle upd_en; that update is dropped.
  - flush_req while in FLUSH is ignored and does not restart the count.
  - upd_en while in FLUSH is dropped.
- **Reset:**
  - Every entry: V=0, T=0, TAG=0, TA=0.
  - state=IDLE, cnt=0.
  - Outputs: busy=0, lk_hit=0, lk_taken=0, lk_next_pc=lk_pc+4.
  - Reset asserted during FLUSH aborts the sequence; the table ends fully invalid.

## Timing
- **Lookup:** zero-cycle latency, combinational path from lk_pc to lk_next_pc.
- **Update visibility:**
  - An update applied at edge N is visible to lookups from cycle N+1.
  - A lookup in the same cycle as an update to the same index sees the old contents; there is no bypass.
- **Flush timing:**
  - busy is a register: 1 from the cycle after flush_req is sampled through the last clearing cycle.
  - Total busy time is exactly ENTRIES cycles; busy is 0 in the following cycle.
  - Lookups miss for the entire busy window.
- **Back-to-back updates:** accepted every cycle, including to the same index; the last write wins.
- **Throughput:** one lookup and one update per cycle.

## Test plan
- **Reset then lookup:** assert rst, release, drive lk_pc=0x0000_0100 -> lk_hit=0, lk_next_pc=0x0000_0104, busy=0.
- **Train taken then predict:** upd_en with upd_pc=0x40, upd_taken=1, upd_target=0x200; next cycle lk_pc=0x40 -> lk_hit=1, lk_taken=1, lk_next_pc=0x200.
- **Not-taken retrain:** after the previous scenario, upd_en with upd_pc=0x40, upd_taken=0 -> lk_hit=1, lk_taken=0, lk_next_pc=0x44. A not-taken update to unallocated 0x80 leaves lk_hit=0 at 0x80.
- **Alias replacement:** ENTRIES=16, train 0x40->0x200, then 0x440->0x300 (same index, different tag). Lookup 0x40 -> miss, next_pc 0x44. Lookup 0x440 -> next_pc 0x300.
- **Flush:** fill all 16 entries, pulse flush_req together with upd_en.
  - busy is high for exactly 16 cycles; the same-cycle update is dropped.
  - Every lookup misses during and after the flush.
  - A second flush_req mid-flush does not extend busy.
- **Reset mid-flush and wrap:**
  - Assert rst at flush cycle 5 -> busy=0 immediately and all entries miss.
  - lk_pc=0xFFFF_FFFC on a miss -> lk_next_pc=0x0000_0000.
